// File: rtl/fc3_ctrl_pkg.sv
// Shared types and constants for the FC3 sequencer: FSM encoding, layer dimensions,
// and the helper that extracts one class score from the packed score bus.
package fc3_ctrl_pkg;

    localparam int N_IN      = 84;
    localparam int N_OUT     = 10;
    localparam int ADDR_W    = 7;
    localparam int RD_LAT    = 1;
    localparam int MAC_LAT   = 2;
    localparam int DW        = 16;
    localparam int IDX_W     = 4;
    localparam int DRAIN_LEN = RD_LAT + MAC_LAT;
    localparam int CMP_LEN   = N_OUT + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_ACC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WR    = 3'd4,
        ST_CMP   = 3'd5,
        ST_DONE  = 3'd6
    } fc3_state_e;

    // class0 sits in the least significant DW bits
    function automatic logic [DW-1:0] score_at(input logic [N_OUT*DW-1:0] all,
                                               input logic [IDX_W-1:0]    idx);
        logic [DW-1:0] r;
        r = {DW{1'b0}};
        for (int i = 0; i < N_OUT; i++) begin
            if (idx == IDX_W'(i)) begin
                r = all[i*DW +: DW];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fc3_ctrl_if.sv
// Handshake, memory-read and result bus between the FC3 sequencer and its environment.
interface fc3_ctrl_if;
    import fc3_ctrl_pkg::*;

    logic                  start;
    logic                  busy;
    logic                  rd_en;
    logic [ADDR_W-1:0]     in_addr;
    logic [ADDR_W-1:0]     w_addr;
    logic                  mac_clr;
    logic                  mac_en;
    logic                  f8_wr_en;
    logic [N_OUT*DW-1:0]   class_all;
    logic [IDX_W-1:0]      class_idx;
    logic [DW-1:0]         class_max;
    logic                  done;

    modport master (
        output start, class_all,
        input  busy, rd_en, in_addr, w_addr, mac_clr, mac_en, f8_wr_en,
               class_idx, class_max, done
    );

    modport slave (
        input  start, class_all,
        output busy, rd_en, in_addr, w_addr, mac_clr, mac_en, f8_wr_en,
               class_idx, class_max, done
    );

endinterface

// File: rtl/fc3_ctrl_argmax.sv
// Sequential signed argmax over the class scores; ties keep the lowest index.
// The published result only changes on the final scan step, so it holds between passes.
module fc3_ctrl_argmax
    import fc3_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    last,
    input  logic [IDX_W-1:0]        idx,
    input  logic signed [DW-1:0]    score,
    output logic [IDX_W-1:0]        class_idx,
    output logic [DW-1:0]           class_max
);

    logic [IDX_W-1:0]      best_idx_r;
    logic signed [DW-1:0]  best_max_r;
    logic [IDX_W-1:0]      class_idx_r;
    logic [DW-1:0]         class_max_r;
    logic                  take_s;
    logic [IDX_W-1:0]      res_idx_s;
    logic signed [DW-1:0]  res_max_s;

    // Strictly-greater replacement of the running maximum
    always_comb begin
        take_s    = (score > best_max_r);
        res_idx_s = best_idx_r;
        res_max_s = best_max_r;
        if (take_s) begin
            res_idx_s = idx;
            res_max_s = score;
        end else begin
            res_idx_s = best_idx_r;
            res_max_s = best_max_r;
        end
    end

    // Running maximum, seeded with the most negative score so class0 always qualifies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_idx_r <= {IDX_W{1'b0}};
            best_max_r <= {DW{1'b0}};
        end else if (clr) begin
            best_idx_r <= {IDX_W{1'b0}};
            best_max_r <= {1'b1, {(DW-1){1'b0}}};
        end else if (en) begin
            best_idx_r <= res_idx_s;
            best_max_r <= res_max_s;
        end
    end

    // Published result, committed together with the last candidate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            class_idx_r <= {IDX_W{1'b0}};
            class_max_r <= {DW{1'b0}};
        end else if (en && last) begin
            class_idx_r <= res_idx_s;
            class_max_r <= res_max_s;
        end
    end

    assign class_idx = class_idx_r;
    assign class_max = class_max_r;

endmodule

// File: rtl/fc3_ctrl.sv
// FC3 layer sequencer: clear, accumulate N_IN inputs, drain, write back, optional argmax.
// Define FC3_ARGMAX_EN to enable the argmax scan over the registered class scores.
module fc3_ctrl
    import fc3_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    fc3_ctrl_if.slave  bus
);

    fc3_state_e         state_r;
    fc3_state_e         state_nx_s;
    logic [ADDR_W-1:0]  cnt_r;
    logic [ADDR_W-1:0]  cnt_nx_s;
    logic [ADDR_W-1:0]  addr_r;
    logic [RD_LAT-1:0]  dly_r;
    logic               busy_r;
    logic               rd_en_r;
    logic               mac_clr_r;
    logic               f8_wr_en_r;
    logic               done_r;

    // Next-state and in-state cycle counter
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = {ADDR_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_nx_s = ST_CLR;
                else           state_nx_s = ST_IDLE;
            end
            ST_CLR: state_nx_s = ST_ACC;
            ST_ACC: begin
                if (cnt_r == ADDR_W'(N_IN - 1)) state_nx_s = ST_DRAIN;
                else                            state_nx_s = ST_ACC;
            end
            ST_DRAIN: begin
                if (cnt_r == ADDR_W'(DRAIN_LEN - 1)) state_nx_s = ST_WR;
                else                                 state_nx_s = ST_DRAIN;
            end
`ifdef FC3_ARGMAX_EN
            ST_WR: state_nx_s = ST_CMP;
`else
            ST_WR: state_nx_s = ST_DONE;
`endif
            ST_CMP: begin
                if (cnt_r == ADDR_W'(CMP_LEN - 1)) state_nx_s = ST_DONE;
                else                               state_nx_s = ST_CMP;
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
        if ((state_nx_s != state_r) || (state_r == ST_IDLE)) begin
            cnt_nx_s = {ADDR_W{1'b0}};
        end else begin
            cnt_nx_s = cnt_r + ADDR_W'(1);
        end
    end

    // State, counter and Moore outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {ADDR_W{1'b0}};
            addr_r     <= {ADDR_W{1'b0}};
            busy_r     <= 1'b0;
            rd_en_r    <= 1'b0;
            mac_clr_r  <= 1'b0;
            f8_wr_en_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            addr_r     <= (state_nx_s == ST_ACC) ? cnt_nx_s : {ADDR_W{1'b0}};
            busy_r     <= (state_nx_s != ST_IDLE);
            rd_en_r    <= (state_nx_s == ST_ACC);
            mac_clr_r  <= (state_nx_s == ST_CLR);
            f8_wr_en_r <= (state_nx_s == ST_WR);
            done_r     <= (state_nx_s == ST_DONE);
        end
    end

    // Read-latency delay line turning rd_en into mac_en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_r <= {RD_LAT{1'b0}};
        end else begin
            dly_r <= RD_LAT'({dly_r, rd_en_r});
        end
    end

    assign bus.busy     = busy_r;
    assign bus.rd_en    = rd_en_r;
    assign bus.in_addr  = addr_r;
    assign bus.w_addr   = addr_r;
    assign bus.mac_clr  = mac_clr_r;
    assign bus.mac_en   = dly_r[RD_LAT-1];
    assign bus.f8_wr_en = f8_wr_en_r;
    assign bus.done     = done_r;

`ifdef FC3_ARGMAX_EN
    logic                  cmp_clr_s;
    logic                  cmp_en_s;
    logic                  cmp_last_s;
    logic [IDX_W-1:0]      cmp_idx_s;
    logic signed [DW-1:0]  cmp_score_s;
    logic [IDX_W-1:0]      am_idx_s;
    logic [DW-1:0]         am_max_s;

    // CMP step 0 only seeds the maximum; steps 1..N_OUT visit class0..class(N_OUT-1)
    assign cmp_clr_s   = (state_r == ST_CMP) && (cnt_r == {ADDR_W{1'b0}});
    assign cmp_en_s    = (state_r == ST_CMP) && (cnt_r != {ADDR_W{1'b0}});
    assign cmp_last_s  = (state_r == ST_CMP) && (cnt_r == ADDR_W'(N_OUT));
    assign cmp_idx_s   = IDX_W'(cnt_r) - 4'd1;
    assign cmp_score_s = score_at(bus.class_all, cmp_idx_s);

    fc3_ctrl_argmax u_argmax (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (cmp_clr_s),
        .en        (cmp_en_s),
        .last      (cmp_last_s),
        .idx       (cmp_idx_s),
        .score     (cmp_score_s),
        .class_idx (am_idx_s),
        .class_max (am_max_s)
    );

    assign bus.class_idx = am_idx_s;
    assign bus.class_max = am_max_s;
`else
    logic unused_class_all_s;

    assign unused_class_all_s = ^bus.class_all;
    assign bus.class_idx      = {IDX_W{1'b0}};
    assign bus.class_max      = {DW{1'b0}};
`endif

endmodule
